morse_tx_controller: RTL and testbench
======================================

// Module: morse_tx_controller
// PURPOSE
//  Sequences one Morse letter transmission per request: pattern lookup, unit-rate timing,
//  MSB-first serialisation, inter-letter gap. Sits between a letter source (keys or a
//  message FSM) and the DotDashOut LED/buzzer path. Adds a req/ack handshake, busy/done
//  status and abort to the free-running divider + shift-register datapath.
// PARAMETERS
//  TICK_DIV   250  clock cycles per Morse unit (>=2); 250 = 0.5 s at 500 Hz ClockIn
//  GAP_UNITS  3    low units appended after each letter (>=1)
//  CNT_W      10   tick counter width; must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//  ClockIn     in   1   system clock, all state on rising edge
//  Reset       in   1   asynchronous, active-high reset
//  Req         in   1   request to send Letter; level, sampled only in IDLE
//  Letter      in   3   0..7 = A..H, sampled on the accepting edge
//  Abort       in   1   synchronous cancel of the transmission in progress
//  Ack         out  1   1-cycle pulse: request accepted
//  Busy        out  1   high from accept until gap complete or abort
//  Done        out  1   1-cycle pulse: letter plus gap finished normally
//  DotDashOut  out  1   serial Morse output, 1 = tone/LED on
// BEHAVIOUR
//  Reset: state=IDLE; Ack=Busy=Done=DotDashOut=0; all counters/shift reg cleared.
//  All outputs registered. Pattern ROM (bits MSB-first, len): A 10111/5, B 111010101/9,
//   C 11101011101/11, D 1110101/7, E 1/1, F 101011101/9, G 111011101/9, H 1010101/7;
//   stored left-justified in a 12-bit shift register plus a 4-bit length.
//  FSM IDLE -> SEND -> GAP -> IDLE.
//  IDLE: Req=1 at edge N -> after edge N: state=SEND, Ack=1 (cleared at N+1), Busy=1,
//   DotDashOut=pattern MSB, bitcnt=len-1, tickcnt=TICK_DIV-1. Req=0: hold, outputs 0.
//  Tick = (tickcnt==0); tickcnt reloads TICK_DIV-1 on tick, else decrements (SEND/GAP).
//   Every bit and gap unit is held exactly TICK_DIV cycles.
//  SEND on tick: bitcnt!=0 -> shift left, DotDashOut=next bit, bitcnt--;
//   bitcnt==0 -> state=GAP, gapcnt=GAP_UNITS-1, DotDashOut=0.
//  GAP on tick: gapcnt!=0 -> gapcnt--; gapcnt==0 -> state=IDLE, Busy=0, Done=1 (1 cycle).
//  Accept-to-Done = (len+GAP_UNITS)*TICK_DIV cycles; Busy high exactly that many cycles.
//  Req while Busy: ignored, no Ack, Letter not latched; Req still high when IDLE is
//   re-entered is accepted on the following edge (back-to-back letters, 1 idle cycle).
//  Abort (SEND or GAP): next edge -> IDLE, DotDashOut=0, Busy=0, no Done. Abort in IDLE
//   has no effect; Abort and Req on the same IDLE edge -> Req accepted.
//  Letter changes after accept have no effect on the letter in flight.
//  Reset mid-transmission: immediate return to reset values, no Done.
// TESTING  (TICK_DIV=4, GAP_UNITS=3 unless stated)
//  E: Req 1 cycle, Letter=4 -> Ack next cycle; DotDashOut 1 for 4 cycles, 0 for 12;
//   Busy 16 cycles; Done pulse on the edge Busy falls.
//  C: Letter=2 -> DotDashOut sampled every 4 cycles = 11101011101 then 000; Busy 56 cycles.
//  Req held high with Letter=0 across two letters -> one Ack per letter, A sent twice,
//   exactly 1 idle cycle between Busy low and next Ack; Req pulses mid-letter -> no Ack.
//  Abort at 3rd bit of B -> next cycle DotDashOut=0, Busy=0, no Done; new Req accepted.
//  Reset asserted asynchronously mid-GAP of D -> outputs 0 without waiting for a clock edge.
//  Default params, Letter=7 -> each unit exactly 250 cycles; Busy = 2500 cycles.

Source files
------------

// File: rtl/morse_tx_controller.sv
// Morse letter transmitter (A..H): accepts one letter per req/ack handshake, then emits its
// dot/dash pattern MSB-first at one bit per unit, followed by a fixed inter-letter gap.
module morse_tx_controller #(
  parameter int unsigned TICK_DIV  = 250,
  parameter int unsigned GAP_UNITS = 3,
  parameter int unsigned CNT_W     = 10
) (
  input  logic       ClockIn,
  input  logic       Reset,
  input  logic       Req,
  input  logic [2:0] Letter,
  input  logic       Abort,
  output logic       Ack,
  output logic       Busy,
  output logic       Done,
  output logic       DotDashOut
);

  localparam int unsigned GapW = (GAP_UNITS > 1) ? $clog2(GAP_UNITS) : 1;
  localparam logic [CNT_W-1:0] TickReload = CNT_W'(TICK_DIV - 1);
  localparam logic [GapW-1:0]  GapReload  = GapW'(GAP_UNITS - 1);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e           state_q, state_d;
  logic [11:0]      shift_q, shift_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic             ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [11:0] rom_pat;
  logic [3:0]  rom_len;
  logic        tick;

  // Patterns are left-justified so the shift register MSB is always the bit on air.
  always_comb begin
    rom_pat = 12'b0;
    rom_len = 4'd1;
    unique case (Letter)
      3'd0: begin rom_pat = 12'b101110000000; rom_len = 4'd5;  end
      3'd1: begin rom_pat = 12'b111010101000; rom_len = 4'd9;  end
      3'd2: begin rom_pat = 12'b111010111010; rom_len = 4'd11; end
      3'd3: begin rom_pat = 12'b111010100000; rom_len = 4'd7;  end
      3'd4: begin rom_pat = 12'b100000000000; rom_len = 4'd1;  end
      3'd5: begin rom_pat = 12'b101011101000; rom_len = 4'd9;  end
      3'd6: begin rom_pat = 12'b111011101000; rom_len = 4'd9;  end
      3'd7: begin rom_pat = 12'b101010100000; rom_len = 4'd7;  end
    endcase
  end

  assign tick = (tick_q == '0);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    tick_d   = tick_q;
    gap_d    = gap_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (Req) begin
          state_d  = StSend;
          shift_d  = rom_pat;
          bitcnt_d = rom_len - 4'd1;
          tick_d   = TickReload;
          ack_d    = 1'b1;
          busy_d   = 1'b1;
        end
      end
      StSend: begin
        tick_d = tick ? TickReload : tick_q - CNT_W'(1);
        if (tick) begin
          if (bitcnt_q != 4'd0) begin
            shift_d  = {shift_q[10:0], 1'b0};
            bitcnt_d = bitcnt_q - 4'd1;
          end else begin
            state_d = StGap;
            gap_d   = GapReload;
            shift_d = '0;
          end
        end
      end
      StGap: begin
        tick_d = tick ? TickReload : tick_q - CNT_W'(1);
        if (tick) begin
          if (gap_q != '0) begin
            gap_d = gap_q - GapW'(1);
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Abort only cancels an active letter; in idle a simultaneous Req still wins.
    if (Abort && (state_q != StIdle)) begin
      state_d = StIdle;
      shift_d = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      bitcnt_q <= '0;
      tick_q   <= '0;
      gap_q    <= '0;
      ack_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      tick_q   <= tick_d;
      gap_q    <= gap_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign Ack        = ack_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign DotDashOut = shift_q[11];

endmodule

// File: tb/tb_morse_tx_controller.sv
// Scoreboard bench for morse_tx_controller: the driver queues expected letters, the monitor
// captures each transmission from Ack to Busy falling and compares it with a unit-level model.
module tb_morse_tx_controller;

  localparam int T = 4;
  localparam int G = 3;

  logic       ClockIn = 1'b0;
  logic       Reset;
  logic       Req, Abort;
  logic [2:0] Letter;
  logic       Ack, Busy, Done, DotDashOut;
  logic       Req2, Abort2;
  logic [2:0] Letter2;
  logic       Ack2, Busy2, Done2, DotDashOut2;

  int tests = 0;
  int fails = 0;

  string pats [8] = '{"10111", "111010101", "11101011101", "1110101",
                      "1", "101011101", "111011101", "1010101"};

  typedef struct {
    int letter;
    int ncyc;
    bit done;
    bit b2b;
  } exp_t;

  exp_t exp_q[$];

  always #5 ClockIn = ~ClockIn;

  morse_tx_controller #(.TICK_DIV(T), .GAP_UNITS(G), .CNT_W(3)) dut (
    .ClockIn(ClockIn), .Reset(Reset), .Req(Req), .Letter(Letter), .Abort(Abort),
    .Ack(Ack), .Busy(Busy), .Done(Done), .DotDashOut(DotDashOut)
  );

  morse_tx_controller dut_def (
    .ClockIn(ClockIn), .Reset(Reset), .Req(Req2), .Letter(Letter2), .Abort(Abort2),
    .Ack(Ack2), .Busy(Busy2), .Done(Done2), .DotDashOut(DotDashOut2)
  );

  // Reference: cycle idx lies in unit idx/t; units past the pattern are gap (0).
  function automatic logic exp_bit(input int l, input int idx, input int t);
    string s;
    int u;
    s = pats[l];
    u = idx / t;
    if (u < s.len()) return (s.getc(u) == 8'h31);
    return 1'b0;
  endfunction

  function automatic int exp_ncyc(input int l, input int t, input int g);
    string s;
    s = pats[l];
    return (s.len() + g) * t;
  endfunction

  // ---------------- monitor ----------------
  logic cap[$];
  bit   capturing = 0;
  int   idle_cnt = 100;
  int   start_gap = 0;
  int   spurious = 0;

  always @(negedge ClockIn) begin
    if (Reset) begin
      capturing = 0;
      cap.delete();
    end else if (capturing) begin
      if (Busy) begin
        if (Ack || Done) spurious++;
        cap.push_back(DotDashOut);
      end else begin
        capturing = 0;
        idle_cnt  = 1;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL sb_unexpected: got transmission of %0d cycles, required none", cap.size());
        end else begin
          exp_t e;
          int bad;
          e = exp_q.pop_front();
          if (cap.size() != e.ncyc) begin
            fails++;
            $display("FAIL busy_len letter %0d: got %0d cycles, required %0d",
                     e.letter, cap.size(), e.ncyc);
          end
          tests++;
          bad = -1;
          for (int i = 0; i < cap.size() && i < e.ncyc; i++)
            if (bad < 0 && cap[i] !== exp_bit(e.letter, i, T)) bad = i;
          if (bad >= 0) begin
            fails++;
            $display("FAIL waveform letter %0d cycle %0d: got %b, required %b",
                     e.letter, bad, cap[bad], exp_bit(e.letter, bad, T));
          end
          tests++;
          if (Done !== e.done) begin
            fails++;
            $display("FAIL done letter %0d: got %b, required %b", e.letter, Done, e.done);
          end
          if (e.b2b) begin
            tests++;
            if (start_gap != 1) begin
              fails++;
              $display("FAIL b2b_gap: got %0d idle cycles, required 1", start_gap);
            end
          end
          tests++;
          if (spurious != 0) begin
            fails++;
            $display("FAIL mid_ack_done letter %0d: got %0d pulses, required 0",
                     e.letter, spurious);
          end
        end
        spurious = 0;
        cap.delete();
      end
    end else if (Ack) begin
      capturing = 1;
      start_gap = idle_cnt;
      cap.delete();
      cap.push_back(DotDashOut);
    end else begin
      idle_cnt++;
    end
  end

  // ---------------- driver ----------------
  task automatic check(input string name, input logic [3:0] got, input logic [3:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s: got %b, required %b", name, got, req);
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge ClockIn);
      if (!Busy) ok = 1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL wait_idle: got Busy stuck 1, required 0");
    end
  endtask

  task automatic send(input int l, input bit pulse_mid, input bit abort_same);
    exp_t e;
    e = '{letter: l, ncyc: exp_ncyc(l, T, G), done: 1'b1, b2b: 1'b0};
    exp_q.push_back(e);
    Req = 1'b1;
    Letter = 3'(l);
    Abort = abort_same;
    @(negedge ClockIn);
    check("ack", {3'b0, Ack}, 4'b1);
    Req = 1'b0;
    Abort = 1'b0;
    Letter = 3'($urandom);
    if (pulse_mid) begin
      repeat (3) @(negedge ClockIn);
      Req = 1'b1;
      @(negedge ClockIn);
      Req = 1'b0;
    end
    wait_idle();
  endtask

  task automatic send_abort(input int l, input int k);
    exp_t e;
    e = '{letter: l, ncyc: k, done: 1'b0, b2b: 1'b0};
    exp_q.push_back(e);
    Req = 1'b1;
    Letter = 3'(l);
    @(negedge ClockIn);
    check("ack_abort", {3'b0, Ack}, 4'b1);
    Req = 1'b0;
    repeat (k - 1) @(negedge ClockIn);
    Abort = 1'b1;
    @(negedge ClockIn);
    Abort = 1'b0;
    check("abort_out", {2'b0, Busy, DotDashOut}, 4'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   cnt, mism;
    Reset = 1'b1; Req = 1'b0; Letter = '0; Abort = 1'b0;
    Req2 = 1'b0; Letter2 = '0; Abort2 = 1'b0;
    repeat (2) @(negedge ClockIn);
    check("reset_outs", {Ack, Busy, Done, DotDashOut}, 4'b0);
    check("reset_outs_def", {Ack2, Busy2, Done2, DotDashOut2}, 4'b0);
    #2 Reset = 1'b0;
    @(negedge ClockIn);

    send(4, 0, 0);              // E
    send(2, 0, 0);              // C
    // A twice with Req held high: second accept one idle cycle after Busy falls
    e = '{letter: 0, ncyc: exp_ncyc(0, T, G), done: 1'b1, b2b: 1'b0};
    exp_q.push_back(e);
    e.b2b = 1'b1;
    exp_q.push_back(e);
    Req = 1'b1;
    Letter = 3'd0;
    @(negedge ClockIn);
    check("ack_b2b_first", {3'b0, Ack}, 4'b1);
    wait_idle();
    @(negedge ClockIn);
    check("ack_b2b_second", {3'b0, Ack}, 4'b1);
    Req = 1'b0;
    wait_idle();

    send_abort(1, 2 * T + 1);   // B aborted during its 3rd bit
    send(5, 0, 1);              // Abort with Req on an idle edge: Req wins
    Abort = 1'b1;
    repeat (2) @(negedge ClockIn);
    check("abort_idle", {2'b0, Busy, Ack}, 4'b0);
    Abort = 1'b0;

    for (int n = 0; n < 12; n++) begin
      int l, mode;
      l = int'($urandom_range(7));
      mode = int'($urandom_range(3));
      repeat ($urandom_range(3)) @(negedge ClockIn);
      if (mode == 2) send_abort(l, int'($urandom_range(exp_ncyc(l, T, G) - 1, 1)));
      else send(l, mode == 3, 0);
    end

    // Async reset during D's gap; no Done and no scoreboard entry expected
    @(negedge ClockIn);
    Req = 1'b1;
    Letter = 3'd3;
    @(negedge ClockIn);
    Req = 1'b0;
    repeat (7 * T + 5) @(negedge ClockIn);
    check("busy_pre_reset", {3'b0, Busy}, 4'b1);
    #2 Reset = 1'b1;
    #1 check("async_reset", {Ack, Busy, Done, DotDashOut}, 4'b0);
    @(negedge ClockIn);
    #2 Reset = 1'b0;
    @(negedge ClockIn);
    send(7, 0, 0);

    // Default parameters, letter H: 10 units of 250 cycles
    Req2 = 1'b1;
    Letter2 = 3'd7;
    @(negedge ClockIn);
    check("ack_def", {3'b0, Ack2}, 4'b1);
    Req2 = 1'b0;
    cnt = 0;
    mism = 0;
    while (Busy2 && cnt < 3000) begin
      if (DotDashOut2 !== exp_bit(7, cnt, 250)) mism++;
      cnt++;
      @(negedge ClockIn);
    end
    tests++;
    if (cnt != 2500) begin
      fails++;
      $display("FAIL busy_def: got %0d cycles, required 2500", cnt);
    end
    tests++;
    if (mism != 0) begin
      fails++;
      $display("FAIL wave_def: got %0d wrong cycles, required 0", mism);
    end
    check("done_def", {3'b0, Done2}, 4'b1);

    repeat (2) @(negedge ClockIn);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: got %0d pending, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
